// File: rtl/satd4x4_datapath.sv
// satd4x4_datapath: 4x4 SATD datapath.
// Rows are Hadamard-transformed into a transpose buffer (LOAD). Columns are then
// transformed one per cycle and their absolute values accumulated (COL). The block
// result is held until it is accepted downstream (DONE).
// Optional macro SATD_HALF_EN: the emitted SATD is (sum+1)>>1 instead of the raw sum.
module satd4x4_datapath #(
    parameter int DW = 9,
    parameter int SW = DW + 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4*DW-1:0] in_row,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   satd,
    output logic [1:0]      stage,
    output logic [1:0]      count
);

    localparam int HW = DW + 2;  // row-transform coefficient width
    localparam int CW = DW + 4;  // column-transform coefficient width
    localparam int AW = CW + 2;  // sum of four column magnitudes

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_COL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_stage, w_stage_next;
    logic [1:0]            r_count, w_count_next;
    logic [SW-1:0]         r_acc, w_acc_next;
    logic [SW-1:0]         r_satd, w_satd_next;
    logic                  r_out_valid, w_out_valid_next;
    logic                  w_buf_we;

    // Transpose buffer: r_buf[row][col], holds the row-transformed coefficients.
    logic signed [HW-1:0]  r_buf [4][4];

    logic signed [HW-1:0]  w_x [4];
    logic signed [HW-1:0]  w_h [4];
    logic signed [CW-1:0]  w_c [4];
    logic signed [CW-1:0]  w_v [4];
    logic [CW-1:0]         w_abs [4];
    logic [AW-1:0]         w_colsum;
    logic [SW-1:0]         w_total;
    logic [SW-1:0]         w_result;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            // Sign-extend incoming residuals and pick the current column from the buffer.
            assign w_x[gi]   = HW'(signed'(in_row[gi*DW +: DW]));
            assign w_c[gi]   = CW'(r_buf[gi][r_count]);
            // Magnitude in CW unsigned bits so that -2^(CW-1) maps to 2^(CW-1).
            assign w_abs[gi] = w_v[gi][CW-1] ? $unsigned(-w_v[gi]) : $unsigned(w_v[gi]);
        end
    endgenerate

    // Horizontal and vertical 4-point Hadamard butterflies.
    always_comb begin
        w_h[0] = (w_x[0] + w_x[1]) + (w_x[2] + w_x[3]);
        w_h[1] = (w_x[0] - w_x[1]) + (w_x[2] - w_x[3]);
        w_h[2] = (w_x[0] + w_x[1]) - (w_x[2] + w_x[3]);
        w_h[3] = (w_x[0] - w_x[1]) - (w_x[2] - w_x[3]);
        w_v[0] = (w_c[0] + w_c[1]) + (w_c[2] + w_c[3]);
        w_v[1] = (w_c[0] - w_c[1]) + (w_c[2] - w_c[3]);
        w_v[2] = (w_c[0] + w_c[1]) - (w_c[2] + w_c[3]);
        w_v[3] = (w_c[0] - w_c[1]) - (w_c[2] - w_c[3]);
    end

    assign w_colsum = AW'(w_abs[0]) + AW'(w_abs[1]) + AW'(w_abs[2]) + AW'(w_abs[3]);
    assign w_total  = r_acc + SW'(w_colsum);

`ifdef SATD_HALF_EN
    // (s+1)>>1 written as (s>>1)+s[0]; the accumulator itself stays unscaled.
    assign w_result = {1'b0, w_total[SW-1:1] + (SW-1)'(w_total[0])};
`else
    assign w_result = w_total;
`endif

    // Next-state, accumulator and result logic.
    always_comb begin
        w_stage_next     = r_stage;
        w_count_next     = r_count;
        w_acc_next       = r_acc;
        w_satd_next      = r_satd;
        w_out_valid_next = r_out_valid;
        w_buf_we         = 1'b0;
        case (r_stage)
            ST_LOAD: begin
                if (in_valid) begin
                    w_buf_we = 1'b1;
                    if (r_count == 2'd3) begin
                        w_stage_next = ST_COL;
                        w_count_next = 2'd0;
                        w_acc_next   = '0;
                    end else begin
                        w_count_next = r_count + 2'd1;
                    end
                end
            end
            ST_COL: begin
                w_acc_next = w_total;
                if (r_count == 2'd3) begin
                    w_stage_next     = ST_DONE;
                    w_count_next     = 2'd0;
                    w_satd_next      = w_result;
                    w_out_valid_next = 1'b1;
                end else begin
                    w_count_next = r_count + 2'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_stage_next     = ST_LOAD;
                    w_count_next     = 2'd0;
                    w_out_valid_next = 1'b0;
                end
            end
            default: begin
                w_stage_next     = ST_LOAD;
                w_count_next     = 2'd0;
                w_out_valid_next = 1'b0;
            end
        endcase
    end

    // Control and result registers; reset aborts any block in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage     <= ST_LOAD;
            r_count     <= 2'd0;
            r_acc       <= '0;
            r_satd      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_stage     <= w_stage_next;
            r_count     <= w_count_next;
            r_acc       <= w_acc_next;
            r_satd      <= w_satd_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    // Transpose buffer write of the transformed row; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_buf_we && !reset) begin
            for (int j = 0; j < 4; j++) begin
                r_buf[r_count][j] <= w_h[j];
            end
        end
    end

    assign in_ready  = (r_stage == ST_LOAD);
    assign out_valid = r_out_valid;
    assign satd      = r_satd;
    assign stage     = r_stage;
    assign count     = r_count;

endmodule

// File: tb/tb_satd4x4_datapath.sv
// Testbench for satd4x4_datapath (DW=9): directed vector table, hand-written
// backpressure/reset sequences, and random blocks against a matrix-form SATD model.
module tb_satd4x4_datapath;

    localparam int DW = 9;
    localparam int SW = DW + 8;
    localparam int BW = 16 * DW;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [4*DW-1:0] in_row;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   satd;
    logic [1:0]      stage;
    logic [1:0]      count;

    int n_checks = 0;
    int n_errors = 0;

    satd4x4_datapath #(.DW(DW), .SW(SW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .out_valid(out_valid), .out_ready(out_ready),
        .satd(satd), .stage(stage), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BW-1:0] blk;
        int            exp;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int half(input int s);
`ifdef SATD_HALF_EN
        return (s + 1) / 2;
`else
        return s;
`endif
    endfunction

    // Element (r,c) lives at bit offset (r*4+c)*DW; each row is one in_row word.
    function automatic logic [BW-1:0] set_el(input logic [BW-1:0] b, input int r, input int c, input int v);
        logic [BW-1:0] o;
        logic [DW-1:0] t;
        o = b;
        t = DW'(v);
        o[(r*4+c)*DW +: DW] = t;
        return o;
    endfunction

    function automatic logic [BW-1:0] fill_all(input int v);
        logic [BW-1:0] b = '0;
        for (int k = 0; k < 16; k++) b = set_el(b, k / 4, k % 4, v);
        return b;
    endfunction

    // Reference: SATD = sum |H X H^T| with the 4x4 Hadamard matrix H.
    function automatic int model_satd(input logic [BW-1:0] b);
        int hm [4][4] = '{'{1, 1, 1, 1}, '{1, -1, 1, -1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}};
        int x [4][4];
        int s = 0;
        logic signed [DW-1:0] t;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                t = b[(r*4+c)*DW +: DW];
                x[r][c] = int'(t);
            end
        for (int u = 0; u < 4; u++)
            for (int v = 0; v < 4; v++) begin
                int acc = 0;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        acc += hm[u][r] * hm[v][c] * x[r][c];
                s += (acc < 0) ? -acc : acc;
            end
        return half(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full block with no stalls, checking stage/count timeline, latency and handshake.
    task automatic run_block(input logic [BW-1:0] blk, input int exp, input string nm);
        for (int r = 0; r < 4; r++) begin
            in_row   = blk[r*4*DW +: 4*DW];
            in_valid = 1'b1;
            tick();
            if (r < 3) begin
                chk({nm, ".load_count"}, count, r + 1);
                chk({nm, ".load_stage"}, stage, 0);
            end else begin
                chk({nm, ".col_stage"}, stage, 1);
                chk({nm, ".col_count0"}, count, 0);
                chk({nm, ".col_in_ready"}, in_ready, 0);
            end
        end
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) begin
                chk({nm, ".col_out_valid"}, out_valid, 0);
                chk({nm, ".col_count"}, count, k);
            end
        end
        chk({nm, ".done_stage"}, stage, 2);
        chk({nm, ".done_count"}, count, 0);
        chk({nm, ".out_valid"}, out_valid, 1);
        chk({nm, ".satd"}, satd, exp);
        $display("block %s: satd=%0d expected=%0d", nm, satd, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, ".hs_out_valid"}, out_valid, 0);
        chk({nm, ".hs_stage"}, stage, 0);
        chk({nm, ".hs_in_ready"}, in_ready, 1);
        chk({nm, ".hs_satd_kept"}, satd, exp);
    endtask

    vec_t vecs [6];

    initial begin
        logic [BW-1:0] b;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_row    = '0;

        vecs[0] = '{blk: fill_all(0),    exp: half(0)};
        vecs[1] = '{blk: fill_all(1),    exp: half(16)};
        vecs[2] = '{blk: set_el('0, 0, 0, 1),  exp: half(16)};
        vecs[3] = '{blk: set_el('0, 0, 0, -1), exp: half(16)};
        vecs[4] = '{blk: fill_all(-256), exp: half(4096)};
        vecs[5] = '{blk: fill_all(255),  exp: half(4080)};

        tick();
        tick();
        reset = 1'b0;
        chk("reset.stage", stage, 0);
        chk("reset.count", count, 0);
        chk("reset.in_ready", in_ready, 1);
        chk("reset.out_valid", out_valid, 0);
        chk("reset.satd", satd, 0);

        for (int i = 0; i < 6; i++) run_block(vecs[i].blk, vecs[i].exp, $sformatf("vec%0d", i));

        // Backpressure: gaps between rows, rows offered in COL/DONE, delayed out_ready.
        b = fill_all(1);
        for (int r = 0; r < 4; r++) begin
            in_row   = b[r*4*DW +: 4*DW];
            in_valid = 1'b1;
            tick();
            if (r < 3) begin
                in_valid = 1'b0;
                for (int g = 0; g < 2; g++) begin
                    tick();
                    chk("gap.count_hold", count, r + 1);
                    chk("gap.stage", stage, 0);
                end
            end
        end
        in_row   = fill_all(-200) >> (12 * DW);
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("bp.out_valid", out_valid, 1);
        chk("bp.satd", satd, half(16));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp.hold_valid", out_valid, 1);
            chk("bp.hold_satd", satd, half(16));
            chk("bp.hold_in_ready", in_ready, 0);
            chk("bp.hold_stage", stage, 2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp.hs_in_ready", in_ready, 1);
        chk("bp.hs_count", count, 0);
        chk("bp.hs_out_valid", out_valid, 0);
        $display("block backpressure: satd=%0d", satd);

        // out_ready while idle is ignored.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_ready.stage", stage, 0);
        chk("idle_ready.out_valid", out_valid, 0);

        // Reset after two accepted rows aborts the block.
        b = fill_all(-256);
        for (int r = 0; r < 2; r++) begin
            in_row   = b[r*4*DW +: 4*DW];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset.stage", stage, 0);
        chk("midreset.count", count, 0);
        chk("midreset.out_valid", out_valid, 0);
        $display("block midreset: aborted after 2 rows");
        run_block(fill_all(1), half(16), "after_reset");

        // Random blocks against the matrix-form model.
        for (int n = 0; n < 20; n++) begin
            b = '0;
            for (int k = 0; k < 16; k++) b = set_el(b, k / 4, k % 4, int'($urandom_range(0, 511)) - 256);
            run_block(b, model_satd(b), $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
